// File: rtl/audio_pkg.sv
// Shared definitions for the audio sample scheduler: state encoding, defaults
// and the sample attenuation helper.
package audio_pkg;

    localparam int unsigned SAMPLE_W       = 16;
    localparam int unsigned FRAME_LEN_DEF  = 256;
    localparam int unsigned STARVE_MAX_DEF = 8;
    localparam int unsigned STARVE_W       = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_PLAY_A = 2'd1;
    localparam logic [1:0] ST_PLAY_B = 2'd2;
    localparam logic [1:0] ST_MUTE   = 2'd3;

    // Arithmetic right shift keeps the sign, so negative samples stay negative.
    function automatic logic [SAMPLE_W-1:0] attenuate(input logic [SAMPLE_W-1:0] sample,
                                                      input logic [2:0]          shift);
        logic signed [SAMPLE_W-1:0] s;
        s = $signed(sample);
        return s >>> shift;
    endfunction

endpackage

// File: rtl/audio_frame_timer.sv
// Free-running frame counter; load strobes on the last cycle of each frame.
module audio_frame_timer #(
    parameter int unsigned FRAME_LEN = 256
) (
    input  logic clk,
    input  logic rst_n,
    output logic load
);

    localparam int unsigned CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    logic [CNT_W-1:0] frame_cnt_q;
    logic [CNT_W-1:0] frame_cnt_d;

    assign load = (frame_cnt_q == CNT_W'(FRAME_LEN - 1));

    always_comb begin
        frame_cnt_d = load ? '0 : frame_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

endmodule

// File: rtl/audio_sample_scheduler.sv
// Arbitrates music (A) and effects (B) sample pairs once per frame, with
// starvation protection for A, mute and volume attenuation.
module audio_sample_scheduler
    import audio_pkg::*;
#(
    parameter int unsigned FRAME_LEN  = FRAME_LEN_DEF,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                a_valid,
    input  logic [SAMPLE_W-1:0] a_left,
    input  logic [SAMPLE_W-1:0] a_right,
    output logic                a_ready,
    input  logic                b_valid,
    input  logic [SAMPLE_W-1:0] b_left,
    input  logic [SAMPLE_W-1:0] b_right,
    output logic                b_ready,
    input  logic                mute,
    input  logic [2:0]          vol_shift,
    output logic [SAMPLE_W-1:0] audio_in_left,
    output logic [SAMPLE_W-1:0] audio_in_right,
    output logic                frame_tick,
    output logic [1:0]          state
);

    logic                load;
    logic [1:0]          state_q, state_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic [SAMPLE_W-1:0] left_q, left_d;
    logic [SAMPLE_W-1:0] right_q, right_d;
    logic                starved;

    audio_frame_timer #(
        .FRAME_LEN (FRAME_LEN)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load)
    );

    assign starved = (starve_q >= STARVE_W'(STARVE_MAX));

    always_comb begin
        if (mute) begin
            state_d = ST_MUTE;
        end else if (starved && a_valid) begin
            state_d = ST_PLAY_A;
        end else if (b_valid) begin
            state_d = ST_PLAY_B;
        end else if (a_valid) begin
            state_d = ST_PLAY_A;
        end else begin
            state_d = ST_IDLE;
        end
    end

    // Counts B wins only while A is actually waiting; mute freezes it.
    always_comb begin
        starve_d = '0;
        unique case (state_d)
            ST_MUTE:   starve_d = starve_q;
            ST_PLAY_B: starve_d = !a_valid ? '0 :
                                  starved  ? starve_q : starve_q + STARVE_W'(1);
            default:   starve_d = '0;
        endcase
    end

    always_comb begin
        left_d  = '0;
        right_d = '0;
        unique case (state_d)
            ST_PLAY_A: begin
                left_d  = attenuate(a_left, vol_shift);
                right_d = attenuate(a_right, vol_shift);
            end
            ST_PLAY_B: begin
                left_d  = attenuate(b_left, vol_shift);
                right_d = attenuate(b_right, vol_shift);
            end
            default: begin
                left_d  = '0;
                right_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            starve_q <= '0;
            left_q   <= '0;
            right_q  <= '0;
        end else if (load) begin
            state_q  <= state_d;
            starve_q <= starve_d;
            left_q   <= left_d;
            right_q  <= right_d;
        end
    end

    assign a_ready        = load && (state_d == ST_PLAY_A);
    assign b_ready        = load && (state_d == ST_PLAY_B);
    assign frame_tick     = load;
    assign state          = state_q;
    assign audio_in_left  = left_q;
    assign audio_in_right = right_q;

endmodule
